// File: rtl/fir_pkg.sv
// Shared types and the accumulator scaling helper for the FIR result reader.
// Optional build macro: FIR_ACC_READER_ROUND_EN selects round-half-up scaling
// instead of truncation.
package fir_pkg;

    typedef logic [31:0] acc_t;
    typedef logic [15:0] sample_t;

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic    sat;
        sample_t value;
    } scaled_t;

    // Unsigned accumulator to 16-bit result; 33-bit intermediate keeps the rounding carry.
    function automatic scaled_t scale_sat(input acc_t acc, input int unsigned shift);
        logic [32:0] t;
        scaled_t     r;
        t = {1'b0, acc};
`ifdef FIR_ACC_READER_ROUND_EN
        t = t + (33'd1 << (shift - 1));
`else
        t = t;
`endif
        t       = t >> shift;
        r.sat   = |t[32:16];
        r.value = r.sat ? 16'hFFFF : t[15:0];
        return r;
    endfunction

endpackage

// File: rtl/fir_result_fifo.sv
// Result FIFO with a registered head word, occupancy count and synchronous clear.
module fir_result_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  sample_t                  wdata,
    input  logic                     pop,
    output sample_t                  rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    sample_t         mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [AW-1:0]   wr_nxt;
    logic [LW-1:0]   level_nxt;
    logic            do_pop;
    logic            full;
    sample_t         head_nxt;

    assign full = (level == LW'(DEPTH));

    // Next pointers/count; the new head bypasses storage when it is being written now.
    always_comb begin
        do_pop    = pop && valid;
        rd_nxt    = rd_ptr + AW'(do_pop);
        wr_nxt    = wr_ptr + AW'(push);
        level_nxt = level + LW'(push) - LW'(do_pop);
        head_nxt  = (push && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            level  <= level_nxt;
            valid  <= (level_nxt != '0);
            if (level_nxt != '0) begin
                rdata <= head_nxt;
            end
        end
    end

    // Credit logic upstream guarantees a free slot for every push.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst || clear) !(push && full));

endmodule

// File: rtl/fir_acc_reader.sv
// Result-side partner of the cascaded FIR: gates the chain enable from a
// valid/ready sample stream, drops priming sums, scales to 16 bits with
// saturation and queues results for a valid/ready reader.
// Optional build macro: FIR_ACC_READER_ROUND_EN (round half up before shifting).
module fir_acc_reader
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SHIFT = 15,
    parameter int unsigned PRIME = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     fir_enable,
    input  acc_t                     acc_in,
    input  logic                     flush,
    output sample_t                  dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     sat_flag,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = LW + 1;
    localparam int unsigned PW = (PRIME > 0) ? $clog2(PRIME + 1) : 1;
    localparam state_t      RST_STATE = (PRIME > 0) ? ST_PRIME : ST_RUN;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   prime_cnt;
    logic [PW-1:0]   prime_cnt_nxt;
    logic            pend;
    logic            push;
    scaled_t         scaled;

    // Credit: occupied slots plus the sum still in the FIR must leave room.
    assign fir_enable   = sample_valid && !rst && !flush &&
                          ((CW'(level) + CW'(pend)) < CW'(DEPTH));
    assign sample_ready = fir_enable;

    assign scaled = scale_sat(acc_in, SHIFT);

    // Remembers that the FIR chain registered a new sum at the last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= fir_enable;
        end
    end

    // Priming state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            prime_cnt <= PW'(PRIME);
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
        end
    end

    // Next state: drop the first PRIME captures, then push every capture.
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        push          = 1'b0;
        if (flush) begin
            state_nxt     = RST_STATE;
            prime_cnt_nxt = PW'(PRIME);
        end else if (pend) begin
            case (state)
                ST_PRIME: begin
                    if (prime_cnt > PW'(1)) begin
                        prime_cnt_nxt = prime_cnt - PW'(1);
                    end else begin
                        prime_cnt_nxt = '0;
                        state_nxt     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    push = 1'b1;
                end
                default: begin
                    state_nxt = RST_STATE;
                end
            endcase
        end
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (push && scaled.sat) begin
            sat_flag <= 1'b1;
        end
    end

    fir_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata (scaled.value),
        .pop   (dout_ready),
        .rdata (dout),
        .valid (dout_valid),
        .level (level)
    );

endmodule

// File: tb/tb_fir_acc_reader.sv
// Bench for fir_acc_reader: a one-register FIR stand-in feeds acc_in, a
// scoreboard queue holds the results the reader must deliver.
module tb_fir_acc_reader;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SHIFT = 15;
    localparam int unsigned PRIME = 3;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef FIR_ACC_READER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [31:0] acc;
        logic [15:0] exp_dout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic          sample_ready;
    logic          fir_enable;
    logic [31:0]   acc_in = '0;
    logic          flush;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          sat_flag;
    logic [LW-1:0] level;

    logic [31:0]   acc_next;
    logic [15:0]   exp_next;
    logic [15:0]   exp_q[$];
    logic [15:0]   prev_dout;
    bit            prev_hold;
    bit            rand_ready;
    bit            last_en;
    int            prime_left;
    int            n_tests = 0;
    int            n_fail  = 0;
    vec_t          vecs[10];

    always #5 clk = ~clk;

    // FIR chain stand-in: the last stage registers the next sum on enable.
    always @(posedge clk) begin
        if (fir_enable) acc_in <= acc_next;
    end

    fir_acc_reader #(
        .DEPTH (DEPTH),
        .SHIFT (SHIFT),
        .PRIME (PRIME)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fir_enable   (fir_enable),
        .acc_in       (acc_in),
        .flush        (flush),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .sat_flag     (sat_flag),
        .level        (level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock step, entered 1 time unit after a falling edge with inputs driven.
    task automatic step();
        #1;
        last_en = fir_enable;
        if (last_en) begin
            if (prime_left > 0) prime_left--;
            else exp_q.push_back(exp_next);
        end
        #1;
        if (!rst && !flush && dout_valid) begin
            if (prev_hold) check("dout_hold", dout, prev_dout);
            if (dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h, required no output", dout);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                end
            end
        end
        prev_hold = !rst && !flush && dout_valid && !dout_ready;
        prev_dout = dout;
        @(negedge clk);
        #1;
    endtask

    task automatic send_try(input logic [31:0] acc, input logic [15:0] exp, input int max_steps,
                            output bit taken);
        taken        = 1'b0;
        acc_next     = acc;
        exp_next     = exp;
        sample_valid = 1'b1;
        for (int i = 0; i < max_steps && !taken; i++) begin
            if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
            step();
            taken = last_en;
        end
        sample_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] acc, input logic [15:0] exp);
        bit t;
        send_try(acc, exp, 40, t);
        check("send_accepted", 32'(t), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_level", 32'(level), 32'd0);
    endtask

    task automatic prime();
        for (int i = 0; i < int'(PRIME); i++) send(32'h00AA_0000 + 32'(i) * 32'h0001_0000, 16'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        sample_valid = 1'b0;
        dout_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        prime_left = PRIME;
        prev_hold  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        check("flush_enable_gated", 32'(last_en), 32'd0);
        flush        = 1'b0;
        sample_valid = 1'b0;
        exp_q.delete();
        prime_left = PRIME;
        prev_hold  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit t;
        int n_taken;

        vecs[0] = '{32'h0002_0000, 16'h0004};
        vecs[1] = '{32'h0000_4000, ROUND ? 16'h0001 : 16'h0000};
        vecs[2] = '{32'h0000_3FFF, 16'h0000};
        vecs[3] = '{32'h0000_8000, 16'h0001};
        vecs[4] = '{32'h0001_7FFF, ROUND ? 16'h0003 : 16'h0002};
        vecs[5] = '{32'h1234_5678, ROUND ? 16'h2469 : 16'h2468};
        vecs[6] = '{32'h7FFF_8000, 16'hFFFF};
        vecs[7] = '{32'h8000_0000, 16'hFFFF};
        vecs[8] = '{32'hFFFF_FFFF, 16'hFFFF};
        vecs[9] = '{32'h0000_C000, ROUND ? 16'h0002 : 16'h0001};

        rst = 1'b1; flush = 1'b0; sample_valid = 1'b0; dout_ready = 1'b0;
        acc_next = '0; exp_next = '0; rand_ready = 1'b0; prev_hold = 1'b0;
        prime_left = PRIME;
        @(negedge clk);
        #1;
        step();
        step();
        // Reset values, with a pending sample held off by reset.
        sample_valid = 1'b1;
        #1;
        check("rst_fir_enable", 32'(fir_enable), 32'd0);
        check("rst_sample_ready", 32'(sample_ready), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        #1;
        sample_valid = 1'b0;
        rst = 1'b0;

        // Pass-through: samples 1..8 scaled by 0x8000, first three dropped.
        dout_ready = 1'b1;
        for (int s = 1; s <= 3; s++) send(32'(s) * 32'h8000, 16'(s));
        send(32'd4 * 32'h8000, 16'd4);
        check("lat_cycle1_valid", 32'(dout_valid), 32'd0);
        step();
        check("lat_cycle2_valid", 32'(dout_valid), 32'd1);
        check("lat_cycle2_dout", 32'(dout), 32'd4);
        for (int s = 5; s <= 8; s++) begin
            send_try(32'(s) * 32'h8000, 16'(s), 1, t);
            check("tput_accept", 32'(t), 32'd1);
        end
        drain();
        check("pass_sat_clean", 32'(sat_flag), 32'd0);

        // Scaling table with random reader backpressure.
        rand_ready = 1'b1;
        foreach (vecs[i]) send(vecs[i].acc, vecs[i].exp_dout);
        drain();

        // Saturation boundary, rounding carry, sticky flag across flush.
        do_reset();
        prime();
        send(32'h7FFF_8000, 16'hFFFF);
        drain();
        check("sat_boundary", 32'(sat_flag), 32'd0);
        send(32'h7FFF_C000, 16'hFFFF);
        drain();
        check("sat_round_carry", 32'(sat_flag), ROUND ? 32'd1 : 32'd0);
        send(32'h8000_0000, 16'hFFFF);
        drain();
        check("sat_set", 32'(sat_flag), 32'd1);
        do_flush();
        check("sat_after_flush", 32'(sat_flag), 32'd1);

        // Backpressure: fill to DEPTH, one pop re-opens credit one cycle later.
        dout_ready = 1'b1;
        prime();
        dout_ready = 1'b0;
        n_taken = 0;
        for (int i = 0; i < 12; i++) begin
            send_try(32'h0003_0000, 16'd6, 1, t);
            n_taken += int'(t);
        end
        check("bp_taken", 32'(n_taken), 32'd8);
        check("bp_level_full", 32'(level), 32'd8);
        dout_ready = 1'b1;
        send_try(32'h0003_0000, 16'd6, 1, t);
        check("bp_pop_no_comb_path", 32'(t), 32'd0);
        dout_ready = 1'b0;
        send_try(32'h0003_0000, 16'd6, 1, t);
        check("bp_reenable", 32'(t), 32'd1);
        send_try(32'h0003_0000, 16'd6, 1, t);
        check("bp_refull", 32'(t), 32'd0);
        check("bp_level_refull", 32'(level), 32'd8);
        drain();

        // Flush with five queued results and one sum in flight.
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'h0010_0000 + 32'(i), 16'h0);
        check("fl_level_before", 32'(level), 32'd5);
        sample_valid = 1'b1;
        do_flush();
        check("fl_level_after", 32'(level), 32'd0);
        check("fl_valid_after", 32'(dout_valid), 32'd0);
        dout_ready = 1'b1;
        for (int i = 0; i < int'(PRIME); i++) send(32'h0055_0000 + 32'(i) * 32'h8000, 16'h0);
        send(32'h0001_0000, 16'd2);
        send(32'h0002_8000, 16'd5);
        drain();

        // Reset mid-stream with five queued results and the sticky flag set.
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i + 1) * 32'h0010_0000, 16'(32'(i + 1) * 32'h20));
        idle(2);
        check("rs_level_before", 32'(level), 32'd5);
        check("rs_sat_before", 32'(sat_flag), 32'd1);
        rst = 1'b1;
        sample_valid = 1'b1;
        step();
        check("rs_enable_gated", 32'(last_en), 32'd0);
        rst = 1'b0;
        sample_valid = 1'b0;
        check("rs_level", 32'(level), 32'd0);
        check("rs_valid", 32'(dout_valid), 32'd0);
        check("rs_dout", 32'(dout), 32'd0);
        check("rs_sat", 32'(sat_flag), 32'd0);
        exp_q.delete();
        prime_left = PRIME;
        prev_hold  = 1'b0;
        dout_ready = 1'b1;
        prime();
        send(32'h0004_0000, 16'd8);
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_acc_reader.md
# fir_acc_reader

Result-side partner of the cascaded FIR tap block. It gates the FIR chain's `enable` strobe from an upstream valid/ready sample stream and captures the final stage's 32-bit `acc_out` one cycle later. It discards the priming results, scales each accumulator to 16 bits with saturation, and buffers the results in a FIFO. Downstream readers (DMA/CPU bridge) see a valid/ready output stream.

## Interface
- `DEPTH`, 8: result FIFO entries, power of two, 2..64.
- `SHIFT`, 15: right shift applied to the accumulator (Q15 coefficients), 1..16.
- `PRIME`, 3: results discarded after reset/flush (taps minus one).
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_valid` in 1: upstream has a sample on the FIR `sample_in`.
- `sample_ready` out 1: equals `fir_enable`; completes the upstream handshake.
- `fir_enable` out 1: drives `enable` of every FIR stage in the chain.
- `acc_in` in 32: last FIR stage's `acc_out`.
- `flush` in 1: empty the FIFO and restart priming.
- `dout` out 16: head result.
- `dout_valid` out 1: FIFO not empty.
- `dout_ready` in 1: consumer accepts `dout`.
- `sat_flag` out 1: sticky; set when any kept result saturated.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Credit rule.** `fir_enable = sample_valid && !rst && !flush && (level + pend < DEPTH)`.
  - `pend` is a register holding the previous cycle's `fir_enable`.
  - `dout_ready` has no combinational path to `fir_enable`; a pop frees credit the following cycle.
- **Capture.** In any cycle with `pend = 1`, `acc_in` holds the new sum.
  - If `prime_cnt > 0`: decrement `prime_cnt` and drop the result.
  - Otherwise: push the scaled result.
- **Priming counter.** `prime_cnt` is loaded with `PRIME` on `rst` and on `flush`.
- **States.**
  - PRIME: `prime_cnt > 0`. Moves to RUN after the last discard.
  - RUN: push every captured result.
  - `rst` or `flush` returns the block to PRIME from either state.
- **Scaling.** `acc_in` is unsigned (the FIR uses unsigned products and wraps modulo 2^32).
  - `t = acc_in >> SHIFT`, computed in 33 bits (33 bits also covers the optional rounding add).
  - If `t > 0xFFFF`: `dout` entry = 0xFFFF and `sat_flag` is set.
- **FIFO pop.** Pop on `dout_valid && dout_ready`.
  - Simultaneous push and pop leaves `level` unchanged.
  - Pop on empty is ignored.
  - Push on full cannot occur by construction; an SVA asserts this.
- **Flush.**
  - In the cycle `flush` is high: `fir_enable = 0`, the FIFO is cleared at the edge, and any `pend` capture is discarded and does not decrement `prime_cnt`.
  - `sat_flag` is not cleared by `flush`; only `rst` clears it.

## Timing
- **Reset values:**
  - `fir_enable` 0, `sample_ready` 0, `dout_valid` 0, `dout` 0, `sat_flag` 0, `level` 0.
  - `pend` 0, `prime_cnt` = `PRIME`.
- **Latency** from a `fir_enable` cycle N (FIR registers at edge N):
  - Capture at edge N+1.
  - `dout_valid` high in cycle N+2.
- **Throughput:** one result per clock while `dout_ready` is held high.
- **Reset mid-operation:** FIFO contents and the in-flight `pend` are lost. Outputs take their reset values in the cycle after `rst`.
- **`dout` stability:** `dout` is registered at the FIFO head and stays stable while `dout_valid && !dout_ready`.

## Configuration
- Macro `FIR_ACC_READER_ROUND_EN`.
  - **Defined:** round half up before shifting, `t = (acc_in + (1 << (SHIFT-1))) >> SHIFT` in 33 bits; carry into bit 16 or above saturates.
  - **Undefined:** truncate, `t = acc_in >> SHIFT`.
- `sat_flag` semantics are the same in both builds.

## Structure
- Package `fir_pkg` holds:
  - `typedef logic [31:0] acc_t`, `typedef logic [15:0] sample_t`.
  - The state enum `{PRIME, RUN}`.
  - Function `scale_sat(acc_t, shift) -> {sat, sample_t}`.
- Sub-module `fir_result_fifo`: synchronous FIFO with registered head, `level`, and `clear`. Scaling and the credit logic stay in the top module.

## Test plan
- **Pass-through:**
  - Setup: single FIR stage with coeff1 = 0x8000, other coefficients 0, `SHIFT` = 15.
  - Stimulus: samples 1..8 with `dout_ready` = 1.
  - Expected: 1, 2, 3 dropped; `dout` = 4, 5, 6, 7, 8, each 2 cycles after its `fir_enable`.
- **Saturation:**
  - Stimulus: `acc_in` = 0x8000_0000 captured in RUN.
  - Expected: `dout` = 0xFFFF and `sat_flag` = 1; the flag survives `flush` and clears only on `rst`.
- **Rounding:**
  - Stimulus: `acc_in` = 0x0000_4000 with `SHIFT` = 15.
  - Expected: `dout` = 1 with `FIR_ACC_READER_ROUND_EN`, 0 without.
  - Edge case: `acc_in` = 0xFFFF_FFFF with rounding gives `dout` = 0xFFFF and `sat_flag` = 1.
- **Backpressure:**
  - Stimulus: `DEPTH` = 8, `dout_ready` = 0, `sample_valid` held high.
  - Expected: `fir_enable` drops once `level` + `pend` = 8, and `level` stays at 8.
  - Then: a single pop re-asserts `fir_enable` exactly one cycle later.
- **Flush mid-stream:**
  - Stimulus: `flush` with `level` = 5 and `pend` = 1.
  - Expected next cycle: `level` = 0 and `dout_valid` = 0; the next 3 captures are discarded.
- **Reset mid-stream:**
  - Stimulus: `rst` with `level` = 5.
  - Expected next cycle: all outputs at their reset values; after release, priming repeats.
